// File: rtl/crddrop_pkg.sv
// Shared definitions for the coordinate-drop block: token decoding helpers,
// control-token constants and the drop-mode FSM states.
package crddrop_pkg;

    function automatic int tok_w(input int data_w);
        return data_w + 1;
    endfunction

    localparam logic [16:0] DONE_TOKEN = 17'h10100;
    localparam logic [1:0]  SEL_STOP   = 2'b00;
    localparam logic [1:0]  SEL_DONE   = DONE_TOKEN[9:8];

    typedef enum logic [1:0] {START, PEEK, FIBER, DONE} state_t;

    function automatic logic is_ctrl(input logic msb);
        return msb;
    endfunction

    function automatic logic is_stop(input logic msb, input logic [1:0] sel);
        return msb && (sel == SEL_STOP);
    endfunction

    function automatic logic is_done(input logic msb, input logic [1:0] sel);
        return msb && (sel == SEL_DONE);
    endfunction

    // Non-stop payloads report an impossible level so callers never see a false level 0.
    function automatic logic [7:0] stop_lvl(input logic [9:0] lo);
        return (lo[9:8] == SEL_STOP) ? lo[7:0] : 8'hFF;
    endfunction

endpackage

// File: rtl/crddrop_if.sv
// Outer/inner coordinate stream handshakes; slave is the block, master the environment.
interface crddrop_if #(parameter int DATA_W = 16);
    import crddrop_pkg::*;

    localparam int TW = tok_w(DATA_W);

    logic [TW-1:0] outer_in;
    logic          outer_in_valid;
    logic          outer_in_ready;
    logic [TW-1:0] inner_in;
    logic          inner_in_valid;
    logic          inner_in_ready;
    logic [TW-1:0] outer_out;
    logic          outer_out_valid;
    logic          outer_out_ready;
    logic [TW-1:0] inner_out;
    logic          inner_out_valid;
    logic          inner_out_ready;

    modport slave (
        input  outer_in, outer_in_valid, inner_in, inner_in_valid,
        input  outer_out_ready, inner_out_ready,
        output outer_in_ready, inner_in_ready,
        output outer_out, outer_out_valid, inner_out, inner_out_valid
    );

    modport master (
        output outer_in, outer_in_valid, inner_in, inner_in_valid,
        output outer_out_ready, inner_out_ready,
        input  outer_in_ready, inner_in_ready,
        input  outer_out, outer_out_valid, inner_out, inner_out_valid
    );

endinterface

// File: rtl/crddrop_gen_reg_fifo.sv
// Small registered FIFO; the head is presented combinationally and reads as zero when empty.
module reg_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && clk_en && !full;
    assign do_rd   = rd_en && clk_en && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/crddrop_gen.sv
// Drops outer coordinates whose inner fiber is empty, forwarding both streams
// through output FIFOs; drop_en=0 turns it into a plain two-stream pass-through.
module crddrop_gen
    import crddrop_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en,
    input  logic             flush,
    input  logic             tile_en,
    input  logic             drop_en,
    crddrop_if.slave         bus,
    output logic [CNT_W-1:0] drop_count
);
    localparam int TW = tok_w(DATA_W);

    state_t        state;
    state_t        state_nxt;
    logic          armed;
    logic          run;
    logic          pass_mode;
    logic          o_vld, o_data, o_stop, o_done;
    logic          i_vld, i_data, i_stop, i_done, i_lvl0;
    logic          o_rdy, i_rdy, o_keep, i_keep, drop_hit;
    logic          o_fire, i_fire;
    logic          o_full, i_full, o_empty, i_empty;
    logic [TW-1:0] o_head, i_head;

    // armed keeps readies low in the first cycle after reset or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      armed <= 1'b0;
        else if (flush)  armed <= 1'b0;
        else if (clk_en) armed <= 1'b1;
    end

    assign run       = armed && !flush && tile_en;
    assign pass_mode = (state == START) && !drop_en;

    assign o_vld  = bus.outer_in_valid && run;
    assign o_data = o_vld && !is_ctrl(bus.outer_in[TW-1]);
    assign o_stop = o_vld && is_stop(bus.outer_in[TW-1], bus.outer_in[9:8]);
    assign o_done = o_vld && is_done(bus.outer_in[TW-1], bus.outer_in[9:8]);
    assign i_vld  = bus.inner_in_valid && run;
    assign i_data = i_vld && !is_ctrl(bus.inner_in[TW-1]);
    assign i_stop = i_vld && is_stop(bus.inner_in[TW-1], bus.inner_in[9:8]);
    assign i_done = i_vld && is_done(bus.inner_in[TW-1], bus.inner_in[9:8]);
    assign i_lvl0 = (stop_lvl(bus.inner_in[9:0]) == 8'd0);

    assign o_fire = o_vld && o_rdy && clk_en;
    assign i_fire = i_vld && i_rdy && clk_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      state <= START;
        else if (flush)  state <= START;
        else if (clk_en) state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            START: begin
                if (!pass_mode && o_fire && o_done) state_nxt = DONE;
                else if (!pass_mode && o_data)      state_nxt = PEEK;
            end
            PEEK:    if (o_fire) state_nxt = i_data ? FIBER : START;
            FIBER:   if (i_fire && i_stop) state_nxt = START;
            DONE:    state_nxt = START;
            default: state_nxt = START;
        endcase
    end

    // o_keep/i_keep say whether a popped token is also written to its output FIFO.
    always_comb begin
        o_rdy    = 1'b0;
        i_rdy    = 1'b0;
        o_keep   = 1'b0;
        i_keep   = 1'b0;
        drop_hit = 1'b0;
        if (run) begin
            if (pass_mode) begin
                o_rdy  = !o_full;
                i_rdy  = !i_full;
                o_keep = 1'b1;
                i_keep = 1'b1;
            end else begin
                case (state)
                    START: begin
                        if (o_stop) begin
                            o_rdy  = !o_full;
                            o_keep = 1'b1;
                        end else if (o_done && i_done && !o_full && !i_full) begin
                            o_rdy  = 1'b1;
                            i_rdy  = 1'b1;
                            o_keep = 1'b1;
                            i_keep = 1'b1;
                        end
                    end
                    PEEK: begin
                        if (o_data && i_data) begin
                            o_rdy  = !o_full;
                            o_keep = 1'b1;
                        end else if (o_data && i_stop && i_lvl0) begin
                            o_rdy    = 1'b1;
                            i_rdy    = 1'b1;
                            drop_hit = clk_en;
                        end else if (o_data && i_stop && !i_full) begin
                            o_rdy    = 1'b1;
                            i_rdy    = 1'b1;
                            i_keep   = 1'b1;
                            drop_hit = clk_en;
                        end
                    end
                    FIBER: begin
                        if (i_data || i_stop) begin
                            i_rdy  = !i_full;
                            i_keep = 1'b1;
                        end
                    end
                    default: begin
                        o_rdy = 1'b0;
                        i_rdy = 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.outer_in_ready = o_rdy;
    assign bus.inner_in_ready = i_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                drop_count <= '0;
        else if (flush)                            drop_count <= '0;
        else if (drop_hit && (drop_count != '1))   drop_count <= drop_count + CNT_W'(1);
    end

    reg_fifo #(.WIDTH(TW), .DEPTH(FIFO_DEPTH)) u_outer_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .flush   (flush),
        .wr_en   (o_fire && o_keep),
        .wr_data (bus.outer_in),
        .rd_en   (bus.outer_out_ready && tile_en),
        .rd_data (o_head),
        .full    (o_full),
        .empty   (o_empty)
    );

    reg_fifo #(.WIDTH(TW), .DEPTH(FIFO_DEPTH)) u_inner_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clk_en  (clk_en),
        .flush   (flush),
        .wr_en   (i_fire && i_keep),
        .wr_data (bus.inner_in),
        .rd_en   (bus.inner_out_ready && tile_en),
        .rd_data (i_head),
        .full    (i_full),
        .empty   (i_empty)
    );

    assign bus.outer_out       = o_head;
    assign bus.outer_out_valid = !o_empty && tile_en;
    assign bus.inner_out       = i_head;
    assign bus.inner_out_valid = !i_empty && tile_en;

endmodule

// File: tb/tb_crddrop_gen.sv
// Directed vector bench for crddrop_gen: stream tables plus backpressure and
// mid-fiber reset sequences.
module tb_crddrop_gen;
    import crddrop_pkg::*;

    localparam int DW = 16;
    localparam int TW = DW + 1;
    typedef logic [TW-1:0] tok_t;
    localparam tok_t D = DONE_TOKEN;

    typedef struct {
        logic drop_en;
        int   n_oi, n_ii, n_oo, n_io, drops;
        tok_t oi [8];
        tok_t ii [8];
        tok_t oo [8];
        tok_t io [8];
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n, clk_en, flush, tile_en, drop_en;
    logic [15:0] drop_count;
    int          errors = 0;
    int          checks = 0;
    int          bp_accepted;
    vec_t        vecs [4];
    string       names [4];
    tok_t        got_o [$];
    tok_t        got_i [$];

    crddrop_if #(.DATA_W(DW)) bus ();

    crddrop_gen #(.DATA_W(DW), .FIFO_DEPTH(2), .CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .flush      (flush),
        .tile_en    (tile_en),
        .drop_en    (drop_en),
        .bus        (bus),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    function automatic tok_t S(input int lvl);
        return {1'b1, 8'h00, 8'(lvl)};
    endfunction

    function automatic tok_t T(input int v);
        return tok_t'(v);
    endfunction

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Tokens are driven on the falling edge; handshakes are judged after the readies settle.
    task automatic applyStimulus(input int v, input bit bp);
        int oi = 0;
        int ii = 0;
        int cyc = 0;
        int idle = 0;
        got_o.delete();
        got_i.delete();
        bp_accepted = 0;
        drop_en = vecs[v].drop_en;
        while (idle < 3 && cyc < 400) begin
            @(negedge clk);
            bus.outer_in_valid = (oi < vecs[v].n_oi);
            if (oi < vecs[v].n_oi) bus.outer_in = vecs[v].oi[oi];
            else                   bus.outer_in = '0;
            bus.inner_in_valid = (ii < vecs[v].n_ii);
            if (ii < vecs[v].n_ii) bus.inner_in = vecs[v].ii[ii];
            else                   bus.inner_in = '0;
            bus.outer_out_ready = !bp || (cyc >= 20);
            bus.inner_out_ready = !bp || (cyc % 3 != 0);
            #1;
            if (bus.outer_in_valid && bus.outer_in_ready) begin
                oi++;
                if (bp && cyc < 20) bp_accepted++;
            end
            if (bus.inner_in_valid && bus.inner_in_ready) ii++;
            if (bus.outer_out_valid && bus.outer_out_ready) got_o.push_back(bus.outer_out);
            if (bus.inner_out_valid && bus.inner_out_ready) got_i.push_back(bus.inner_out);
            if (bp && cyc == 19) begin
                check_val("bp_outer_in_ready", 32'(bus.outer_in_ready), 32'd0);
                check_val("bp_accepted", 32'(bp_accepted), 32'd2);
            end
            if (oi == vecs[v].n_oi && ii == vecs[v].n_ii && !bus.outer_out_valid && !bus.inner_out_valid)
                idle++;
            else
                idle = 0;
            cyc++;
        end
        if (idle < 3) begin
            checks++;
            errors++;
            $display("[TB] FAIL timeout vector %0d: got %0d cycles, want drain within 400", v, cyc);
        end
        bus.outer_in_valid = 1'b0;
        bus.inner_in_valid = 1'b0;
    endtask

    task automatic checkOutput(input int v, input string tag);
        check_val({tag, "_outer_len"}, 32'(got_o.size()), 32'(vecs[v].n_oo));
        for (int i = 0; i < vecs[v].n_oo && i < got_o.size(); i++)
            check_val($sformatf("%s_outer[%0d]", tag, i), 32'(got_o[i]), 32'(vecs[v].oo[i]));
        check_val({tag, "_inner_len"}, 32'(got_i.size()), 32'(vecs[v].n_io));
        for (int i = 0; i < vecs[v].n_io && i < got_i.size(); i++)
            check_val($sformatf("%s_inner[%0d]", tag, i), 32'(got_i[i]), 32'(vecs[v].io[i]));
        check_val({tag, "_drops"}, 32'(drop_count), 32'(vecs[v].drops));
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check_val("flush_drops", 32'(drop_count), 32'd0);
        check_val("flush_valids", 32'({bus.outer_out_valid, bus.inner_out_valid}), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        clk_en  = 1'b1;
        flush   = 1'b0;
        tile_en = 1'b1;
        drop_en = 1'b1;
        bus.outer_in = '0;
        bus.inner_in = '0;
        bus.outer_in_valid  = 1'b0;
        bus.inner_in_valid  = 1'b0;
        bus.outer_out_ready = 1'b1;
        bus.inner_out_ready = 1'b1;

        names = '{"normal", "empty_mid", "empty_last", "pass"};
        vecs[0].drop_en = 1'b1;
        vecs[0].n_oi = 4; vecs[0].oi = '{T(2), T(5), S(0), D, '0, '0, '0, '0};
        vecs[0].n_ii = 6; vecs[0].ii = '{T(7), S(0), T(3), T(4), S(1), D, '0, '0};
        vecs[0].n_oo = 4; vecs[0].oo = vecs[0].oi;
        vecs[0].n_io = 6; vecs[0].io = vecs[0].ii;
        vecs[0].drops = 0;
        vecs[1].drop_en = 1'b1;
        vecs[1].n_oi = 5; vecs[1].oi = '{T(1), T(3), T(6), S(0), D, '0, '0, '0};
        vecs[1].n_ii = 6; vecs[1].ii = '{T(9), S(0), S(0), T(8), S(1), D, '0, '0};
        vecs[1].n_oo = 4; vecs[1].oo = '{T(1), T(6), S(0), D, '0, '0, '0, '0};
        vecs[1].n_io = 5; vecs[1].io = '{T(9), S(0), T(8), S(1), D, '0, '0, '0};
        vecs[1].drops = 1;
        vecs[2].drop_en = 1'b1;
        vecs[2].n_oi = 4; vecs[2].oi = '{T(1), T(4), S(0), D, '0, '0, '0, '0};
        vecs[2].n_ii = 4; vecs[2].ii = '{T(5), S(0), S(1), D, '0, '0, '0, '0};
        vecs[2].n_oo = 3; vecs[2].oo = '{T(1), S(0), D, '0, '0, '0, '0, '0};
        vecs[2].n_io = 4; vecs[2].io = vecs[2].ii;
        vecs[2].drops = 1;
        vecs[3] = vecs[1];
        vecs[3].drop_en = 1'b0;
        vecs[3].n_oo = 5; vecs[3].oo = vecs[1].oi;
        vecs[3].n_io = 6; vecs[3].io = vecs[1].ii;
        vecs[3].drops = 0;

        repeat (2) @(negedge clk);
        #1;
        check_val("rst_outer_valid", 32'(bus.outer_out_valid), 32'd0);
        check_val("rst_inner_valid", 32'(bus.inner_out_valid), 32'd0);
        check_val("rst_readies", 32'({bus.outer_in_ready, bus.inner_in_ready}), 32'd0);
        check_val("rst_outer_data", 32'(bus.outer_out), 32'd0);
        check_val("rst_drops", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 4; v++) begin
            applyStimulus(v, 1'b0);
            checkOutput(v, names[v]);
            do_flush();
        end

        applyStimulus(0, 1'b1);
        checkOutput(0, "backpressure");

        applyStimulus(1, 1'b0);
        checkOutput(1, "pre_reset");

        // Park the FSM in FIBER with outer coord 2 buffered, then pull reset.
        @(negedge clk);
        drop_en = 1'b1;
        bus.outer_out_ready = 1'b0;
        bus.inner_out_ready = 1'b0;
        bus.outer_in = T(2);
        bus.outer_in_valid = 1'b1;
        bus.inner_in = T(7);
        bus.inner_in_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus.outer_in_valid = 1'b0;
        #1;
        check_val("fiber_outer_valid", 32'(bus.outer_out_valid), 32'd1);
        check_val("fiber_inner_ready", 32'(bus.inner_in_ready), 32'd1);
        check_val("fiber_drops", 32'(drop_count), 32'd1);
        tile_en = 1'b0;
        #1;
        check_val("tile_off_valid", 32'(bus.outer_out_valid), 32'd0);
        check_val("tile_off_ready", 32'(bus.inner_in_ready), 32'd0);
        tile_en = 1'b1;
        bus.inner_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("midrst_valids", 32'({bus.outer_out_valid, bus.inner_out_valid}), 32'd0);
        check_val("midrst_drops", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(0, 1'b0);
        checkOutput(0, "post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
